// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-lane TDM receive demultiplexer.
package tdm_demux4_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_demux4_dec2to4.sv
// One-hot 2-to-4 decoder: the structural inverse of the transmit-side mux4.
module demux_dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4-lane TDM link: collects one word per slot and
// publishes all four lanes together once a full frame has arrived.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] lane0,
  output logic [WIDTH-1:0] lane1,
  output logic [WIDTH-1:0] lane2,
  output logic [WIDTH-1:0] lane3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             sync_err
);

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] lane0_q, lane0_d;
  logic [WIDTH-1:0] lane1_q, lane1_d;
  logic [WIDTH-1:0] lane2_q, lane2_d;
  logic [WIDTH-1:0] lane3_q, lane3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  logic       we_en;
  logic [1:0] we_sel;
  logic [3:0] we;

  // A frame-start word always lands in slot 0, even when it resyncs mid-frame;
  // in IDLE only a frame-start word is accepted.
  assign we_en  = din_valid && ((state_q == ST_RECV) || frame_start);
  assign we_sel = frame_start ? SLOT0 : slot_q;

  demux_dec2to4 u_dec (
    .en  (we_en),
    .sel (we_sel),
    .y   (we)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            slot_d  = SLOT1;
            state_d = ST_RECV;
          end
        end
        ST_RECV: begin
          if (frame_start) begin
            sync_err_d = 1'b1;
            slot_d     = SLOT1;
          end else if (slot_q == SLOT3) begin
            frame_valid_d = 1'b1;
            slot_d        = SLOT0;
            state_d       = ST_IDLE;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shadow0_d = we[0] ? din : shadow0_q;
    shadow1_d = we[1] ? din : shadow1_q;
    shadow2_d = we[2] ? din : shadow2_q;
    lane0_d   = lane0_q;
    lane1_d   = lane1_q;
    lane2_d   = lane2_q;
    lane3_d   = lane3_q;
    // The slot-3 word bypasses the shadows so all lanes switch on one edge.
    if (we[3]) begin
      lane0_d = shadow0_q;
      lane1_d = shadow1_q;
      lane2_d = shadow2_q;
      lane3_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_q        <= SLOT0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      lane0_q       <= '0;
      lane1_q       <= '0;
      lane2_q       <= '0;
      lane3_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      lane0_q       <= lane0_d;
      lane1_q       <= lane1_d;
      lane2_q       <= lane2_d;
      lane3_q       <= lane3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign lane0       = lane0_q;
  assign lane1       = lane1_q;
  assign lane2       = lane2_q;
  assign lane3       = lane3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign slot        = slot_q;

endmodule
